// File: rtl/sdram_pro_ref_pkg.sv
// Shared constants for the SDRAM refresh scheduler.
// State encodings and the default refresh interval.
package sdram_pro_ref_pkg;

  localparam logic [2:0] ST_WAIT_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_GRANT     = 3'd3;

  localparam int unsigned TREFI_CYC_DEF = 780;

endpackage

// File: rtl/sdram_pro_ref_timer.sv
// Refresh-interval timer: counts 0..TREFI_CYC-1 while run is high.
// tick is the wrap cycle; the count is held at 0 while run is low.
module sdram_pro_ref_timer
  import sdram_pro_ref_pkg::*;
#(
  parameter int unsigned TREFI_CYC = TREFI_CYC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned TW =
    (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TREFI_CYC - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_pro_ref_sched.sv
// Refresh scheduler: tracks owed refreshes and requests them
// from the arbiter, flagging urgency and budget overflow.
module sdram_pro_ref_sched
  import sdram_pro_ref_pkg::*;
#(
  parameter int unsigned TREFI_CYC  = TREFI_CYC_DEF,
  parameter int unsigned MAX_PEND   = 8,
  parameter int unsigned URGENT_LVL = 6
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       init_end,
  input  logic       atref_en,
  input  logic       atref_end,
  output logic       atref_req,
  output logic       atref_urgent,
  output logic [3:0] pend_cnt,
  output logic       ref_overflow
);

  localparam logic [3:0] MAX4 = 4'(MAX_PEND);
  localparam logic [3:0] URG4 = 4'(URGENT_LVL);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] delta;
  logic       urg_q;
  logic       urg_d;
  logic       ovf_q;
  logic       ovf_d;
  logic       run;
  logic       tick;
  logic       dec;

  assign run = (state_q != ST_WAIT_INIT);

  sdram_pro_ref_timer #(
    .TREFI_CYC (TREFI_CYC)
  ) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (run),
    .tick    (tick)
  );

  assign dec = (state_q == ST_GRANT) && atref_end
            && (pend_q != 4'd0);

  // One adder: delta is +1, -1 (4'hF) or 0.
  always_comb begin
    delta = 4'd0;
    ovf_d = ovf_q;
    if (tick && !dec) begin
      if (pend_q == MAX4) begin
        ovf_d = 1'b1;
      end else begin
        delta = 4'd1;
      end
    end else if (dec && !tick) begin
      delta = 4'hF;
    end
    pend_d = pend_q + delta;
    urg_d  = (pend_d >= URG4);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_INIT: begin
        if (init_end) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pend_q != 4'd0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (atref_en) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (atref_end) begin
          state_d = (pend_d != 4'd0) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_WAIT_INIT;
      pend_q  <= 4'd0;
      urg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      urg_q   <= urg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign atref_req    = (state_q == ST_REQ);
  assign atref_urgent = urg_q;
  assign pend_cnt     = pend_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_sdram_pro_ref_sched.sv
// Bench for sdram_pro_ref_sched: randomized idle noise checked
// against a cycle-counting model of owed refreshes.
module tb_sdram_pro_ref_sched;

  localparam int TREFI = 16;
  localparam int MAXP  = 4;
  localparam int URG   = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       init_end;
  logic       atref_en;
  logic       atref_end;
  logic       atref_req;
  logic       atref_urgent;
  logic [3:0] pend_cnt;
  logic       ref_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_ready;
  bit m_granted;
  bit m_req;
  bit m_urg;
  bit m_ovf;
  int m_owed;
  int m_age;

  sdram_pro_ref_sched #(
    .TREFI_CYC  (TREFI),
    .MAX_PEND   (MAXP),
    .URGENT_LVL (URG)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_end     (init_end),
    .atref_en     (atref_en),
    .atref_end    (atref_end),
    .atref_req    (atref_req),
    .atref_urgent (atref_urgent),
    .pend_cnt     (pend_cnt),
    .ref_overflow (ref_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_ready = 0; m_granted = 0; m_req = 0;
    m_urg = 0; m_ovf = 0; m_owed = 0; m_age = 0;
  endtask

  // Refresh ticks fall every TREFI cycles counted from init_end.
  task automatic model_edge(input logic i, input logic en,
                            input logic e);
    bit tick;
    bit done;
    int prev;
    if (!m_ready) begin
      if (i) begin
        m_ready = 1;
        m_age = 0;
      end
      return;
    end
    m_age++;
    tick = (m_age % TREFI) == 0;
    done = m_granted && e;
    prev = m_owed;
    if (tick && !done) begin
      if (m_owed == MAXP) m_ovf = 1;
      else m_owed++;
    end else if (done && !tick) begin
      m_owed--;
    end
    if (m_granted) begin
      if (done) begin
        m_granted = 0;
        m_req = (m_owed > 0);
      end
    end else if (m_req) begin
      if (en) begin
        m_req = 0;
        m_granted = 1;
      end
    end else begin
      m_req = (prev > 0);
    end
    m_urg = (m_owed >= URG);
  endtask

  task automatic cycle(input logic i, input logic en,
                       input logic e);
    init_end = i;
    atref_en = en;
    atref_end = e;
    @(posedge sys_clk);
    model_edge(i, en, e);
    #1;
    init_end = 0;
    atref_en = 0;
    atref_end = 0;
  endtask

  // Noise that must be ignored: late init_end, en outside REQ,
  // end outside GRANT.
  task automatic idle_cycle();
    logic i, en, e;
    i  = m_ready && ($urandom_range(0, 3) == 0);
    en = !m_req && ($urandom_range(0, 2) == 0);
    e  = !m_granted && ($urandom_range(0, 2) == 0);
    cycle(i, en, e);
  endtask

  task automatic test_reset();
    sys_rst = 1; init_end = 0; atref_en = 0; atref_end = 0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_checks++;
    if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !== 7'd0)
      $display("FAIL reset_state: got %b exp %b",
        {atref_req, atref_urgent, ref_overflow, pend_cnt}, 7'd0);
    else n_pass++;
    sys_rst = 0;
    // Reset released during cycle 0; idle through cycle 9.
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)})
        $display("FAIL pre_init c%0d: got %b exp %b", k,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {m_req, m_urg, m_ovf, 4'(m_owed)});
      else n_pass++;
      if (k < 9) idle_cycle();
    end
  endtask

  task automatic test_first_req();
    logic [4:0] exp_v;
    cycle(1, 0, 0);
    for (int k = 11; k <= 28; k++) begin
      exp_v = {(k >= 28) ? 1'b1 : 1'b0,
               (k >= 27) ? 4'd1 : 4'd0};
      n_checks++;
      if ({atref_req, pend_cnt} !== exp_v)
        $display("FAIL first_tick c%0d: got %b exp %b", k,
          {atref_req, pend_cnt}, exp_v);
      else n_pass++;
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)})
        $display("FAIL first_model c%0d: got %b exp %b", k,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {m_req, m_urg, m_ovf, 4'(m_owed)});
      else n_pass++;
      idle_cycle();
    end
  endtask

  task automatic test_grant();
    bool_loop: begin end
    cycle(0, 1, 0);
    n_checks++;
    if (atref_req !== 1'b0)
      $display("FAIL grant_drop: got %b exp 0", atref_req);
    else n_pass++;
    repeat (4) cycle(0, 0, 0);
    cycle(0, 0, 1);
    n_checks++;
    if ({atref_req, pend_cnt} !== 5'd0)
      $display("FAIL grant_done: got %b exp %b",
        {atref_req, pend_cnt}, 5'd0);
    else n_pass++;
    for (int k = 0; k < 40 && m_owed == 0; k++) begin
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)} || atref_req !== 1'b0)
        $display("FAIL grant_idle k%0d: got %b exp %b", k,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {m_req, m_urg, m_ovf, 4'(m_owed)});
      else n_pass++;
      idle_cycle();
    end
    idle_cycle();
    n_checks++;
    if ({atref_req, pend_cnt} !== 5'b1_0001)
      $display("FAIL grant_rereq: got %b exp %b",
        {atref_req, pend_cnt}, 5'b1_0001);
    else n_pass++;
  endtask

  task automatic test_no_grant3();
    int k;
    for (k = 0; k < 60 && m_owed < 3; k++) begin
      idle_cycle();
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)} || atref_req !== 1'b1)
        $display("FAIL hold_req k%0d: got %b exp %b", k,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {1'b1, m_urg, m_ovf, 4'(m_owed)});
      else n_pass++;
    end
    n_checks++;
    if ({atref_req, atref_urgent, pend_cnt} !== 6'b11_0011)
      $display("FAIL urgent3: got %b exp %b",
        {atref_req, atref_urgent, pend_cnt}, 6'b11_0011);
    else n_pass++;
  endtask

  task automatic test_saturate();
    sys_rst = 1;
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 0;
    cycle(1, 0, 0);
    for (int k = 0; k < 100 && !m_ovf; k++) begin
      idle_cycle();
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)} || pend_cnt > 4'd4)
        $display("FAIL sat k%0d: got %b exp %b", k,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {m_req, m_urg, m_ovf, 4'(m_owed)});
      else n_pass++;
    end
    n_checks++;
    if ({ref_overflow, pend_cnt} !== 5'b1_0100)
      $display("FAIL overflow: got %b exp %b",
        {ref_overflow, pend_cnt}, 5'b1_0100);
    else n_pass++;
    for (int g = 0; g < 20 && m_owed > 0; g++) begin
      repeat ($urandom_range(0, 3)) idle_cycle();
      cycle(0, 1, 0);
      repeat ($urandom_range(1, 4)) idle_cycle();
      cycle(0, 0, 1);
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
          {m_req, m_urg, m_ovf, 4'(m_owed)} ||
          atref_req !== (pend_cnt != 0) || ref_overflow !== 1'b1)
        $display("FAIL drain g%0d: got %b exp %b", g,
          {atref_req, atref_urgent, ref_overflow, pend_cnt},
          {m_req, m_urg, 1'b1, 4'(m_owed)});
      else n_pass++;
    end
    n_checks++;
    if (pend_cnt !== 4'd0)
      $display("FAIL drained: got %0d exp 0", pend_cnt);
    else n_pass++;
  endtask

  task automatic test_coincident();
    for (int k = 0; k < 60 && !(m_owed == 2 && m_req); k++)
      idle_cycle();
    cycle(0, 1, 0);
    for (int k = 0; k < 20 && (m_age + 1) % TREFI != 0; k++)
      cycle(0, 0, 0);
    cycle(0, 0, 1);
    n_checks++;
    if ({atref_req, pend_cnt} !== 5'b1_0010)
      $display("FAIL coincident: got %b exp %b",
        {atref_req, pend_cnt}, 5'b1_0010);
    else n_pass++;
    n_checks++;
    if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !==
        {m_req, m_urg, m_ovf, 4'(m_owed)})
      $display("FAIL coinc_model: got %b exp %b",
        {atref_req, atref_urgent, ref_overflow, pend_cnt},
        {m_req, m_urg, m_ovf, 4'(m_owed)});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_v;
    for (int k = 0; k < 60 && m_owed < 3; k++) idle_cycle();
    cycle(0, 1, 0);
    n_checks++;
    if ({atref_req, pend_cnt} !== 5'b0_0011)
      $display("FAIL mid_grant: got %b exp %b",
        {atref_req, pend_cnt}, 5'b0_0011);
    else n_pass++;
    #3;
    sys_rst = 1;
    #1;
    model_reset();
    n_checks++;
    if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !== 7'd0)
      $display("FAIL async_rst: got %b exp %b",
        {atref_req, atref_urgent, ref_overflow, pend_cnt}, 7'd0);
    else n_pass++;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 0;
    repeat ($urandom_range(3, 8)) begin
      idle_cycle();
      n_checks++;
      if ({atref_req, atref_urgent, ref_overflow, pend_cnt} !== 7'd0)
        $display("FAIL no_init: got %b exp %b",
          {atref_req, atref_urgent, ref_overflow, pend_cnt}, 7'd0);
      else n_pass++;
    end
    cycle(1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      exp_v = {(k >= 18) ? 1'b1 : 1'b0,
               (k >= 17) ? 4'd1 : 4'd0};
      n_checks++;
      if ({atref_req, pend_cnt} !== exp_v)
        $display("FAIL reinit k%0d: got %b exp %b", k,
          {atref_req, pend_cnt}, exp_v);
      else n_pass++;
      idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_first_req();
    test_grant();
    test_no_grant3();
    test_saturate();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
